oddr_serializer: RTL

Transmit-side counterpart of the input DDR capture primitive: accepts parallel words over a valid/ready handshake and drives them out of one DDR pin, two bits per clock cycle (one on the high phase, one on the low phase). It sits at the FPGA output boundary in Verilator-simulated designs and feeds source-synchronous links whose far end is an input DDR receiver. It is built from a single-bit DDR output cell plus a shift/count controller.

---
 rtl/oddr_pkg.sv | 25 ++
 rtl/oddr_cell.sv | 36 +++
 rtl/oddr_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/oddr_pkg.sv
// Shared definitions for the DDR output serializer: state encoding and
// beat-counter sizing helpers.
package oddr_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } oddr_state_e;

  localparam oddr_state_e ST_IDLE  = StIdle;
  localparam oddr_state_e ST_SHIFT = StShift;

  // Number of two-bit beats needed to send one parallel word.
  function automatic int unsigned oddr_beats(input int unsigned data_width);
    return data_width / 2;
  endfunction

  // Beat counter width; never narrower than one bit so a 2-bit word still works.
  function automatic int unsigned oddr_cnt_width(input int unsigned data_width);
    int unsigned w;
    w = $clog2(data_width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/oddr_cell.sv
// Single-bit DDR output cell. D1 is driven during the high phase of C, D2
// during the following low phase. The low-phase bit is retimed onto the
// falling edge so it stays stable for the whole low phase.
module oddr_cell (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic D1,
  input  logic D2,
  input  logic INIT,
  output logic Q
);

  logic qr;
  logic qf_pend;
  logic qf;

  // Rising-edge capture of both phase bits; reset wins over CE.
  always_ff @(posedge C) begin
    if (R) begin
      qr      <= INIT;
      qf_pend <= INIT;
    end else if (CE) begin
      qr      <= D1;
      qf_pend <= D2;
    end
  end

  // Falling-edge retime; qf_pend is already frozen while CE is low, so no gating needed.
  always_ff @(negedge C) begin
    qf <= qf_pend;
  end

  assign Q = C ? qr : qf;

endmodule

// File: rtl/oddr_serializer.sv
// Parallel-to-DDR serializer: accepts words over valid/ready and streams them
// two bits per cycle through one oddr_cell. Back-to-back words leave no gap
// because ready is raised combinationally on the last beat.
module oddr_serializer
  import oddr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        INIT_Q     = 1'b0,
  parameter logic        IDLE_Q     = 1'b0,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  D_VALID,
  output logic                  D_READY,
  output logic                  Q,
  output logic                  Q_EN
);

  localparam int unsigned Beats = oddr_beats(DATA_WIDTH);
  localparam int unsigned CntW  = oddr_cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(Beats - 1);

  oddr_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  started_q, started_d;
  logic                  q_en_q, q_en_d;
  logic                  last_beat;
  logic                  accept;
  logic                  d1, d2;

  // Handshake decode from registered state.
  always_comb begin
    last_beat = (state_q == ST_SHIFT) && (cnt_q == CntLast);
    D_READY   = CE & ~R & ((state_q == ST_IDLE) | last_beat);
    accept    = D_VALID & D_READY;
  end

  // Next-state, shifter and output-cell feed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    started_d = started_q;
    q_en_d    = 1'b0;
    // Until the first word goes out the line keeps showing the reset level.
    d1        = started_q ? IDLE_Q : INIT_Q;
    d2        = started_q ? IDLE_Q : INIT_Q;

    if (state_q == ST_SHIFT) begin
      q_en_d    = 1'b1;
      started_d = 1'b1;
      cnt_d     = cnt_q + CntW'(1);
      if (MSB_FIRST) begin
        d1   = sr_q[DATA_WIDTH-1];
        d2   = sr_q[DATA_WIDTH-2];
        sr_d = sr_q << 2;
      end else begin
        d1   = sr_q[0];
        d2   = sr_q[1];
        sr_d = sr_q >> 2;
      end
      if (last_beat) begin
        state_d = ST_IDLE;
      end
    end

    // A new word overrides the shift; the current pair still goes to the cell.
    if (accept) begin
      sr_d    = D;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end
  end

  // Controller state; reset takes priority over CE and over an accept.
  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      started_q <= 1'b0;
      q_en_q    <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      started_q <= started_d;
      q_en_q    <= q_en_d;
    end
  end

  assign Q_EN = q_en_q;

  oddr_cell u_cell (
    .C    (C),
    .R    (R),
    .CE   (CE),
    .D1   (d1),
    .D2   (d2),
    .INIT (INIT_Q),
    .Q    (Q)
  );

endmodule
